retire_trace_buffer: RTL and testbench

Parametrised trace capture block for the pipelined RV32I core; the successor to the free-running debug monitor. It records retire events (PC, instruction, register writeback) into a circular buffer while armed. It stops a programmable number of entries after a PC-match trigger, then drains entries oldest-first over a valid/ready read port. It sits beside processor_pipe_top on the writeback stage and is driven by the bench or a debug host.

---
 rtl/retire_trace_buffer.sv | 197 +++++++++++++++++++
 tb/tb_retire_trace_buffer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/retire_trace_buffer.sv
// rtl/retire_trace_buffer.sv - retire-event trace buffer: PC trigger, post-trigger capture, oldest-first drain
// Optional TRACE_TIMESTAMP_EN stores a free-running cycle stamp with every captured entry.
module retire_trace_buffer #(
    parameter int XLEN      = 32,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 8,
    parameter int TS_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cap_valid,
    input  logic [XLEN-1:0]       cap_pc,
    input  logic [31:0]           cap_instr,
    input  logic                  cap_rd_we,
    input  logic [4:0]            cap_rd_addr,
    input  logic [XLEN-1:0]       cap_rd_data,
    input  logic                  arm,
    input  logic                  abort,
    input  logic                  trig_en,
    input  logic [XLEN-1:0]       trig_pc,
    input  logic                  rd_ready,
    output logic                  rd_valid,
    output logic [XLEN-1:0]       rd_pc,
    output logic [31:0]           rd_instr,
    output logic                  rd_we,
    output logic [4:0]            rd_addr,
    output logic [XLEN-1:0]       rd_data,
    output logic [TS_WIDTH-1:0]   rd_ts,
    output logic [1:0]            state,
    output logic [$clog2(DEPTH):0] count,
    output logic                  wrapped
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ARMED = 2'b01,
        S_POST  = 2'b10,
        S_DRAIN = 2'b11
    } state_t;

    state_t          state_q;
    logic [AW-1:0]   wptr_q;
    logic [AW-1:0]   rptr_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   post_q;
    logic            wrapped_q;

    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [31:0]     instr_mem[DEPTH];
    logic            we_mem   [DEPTH];
    logic [4:0]      addr_mem [DEPTH];
    logic [XLEN-1:0] data_mem [DEPTH];

    logic            store;
    logic            trig_hit;
    logic            full;
    logic            pop;
    logic            load_first;
    logic            rd_load;
    logic [AW-1:0]   rptr_nxt;
    logic [AW-1:0]   rd_idx;

    assign store      = cap_valid && (state_q == S_ARMED || state_q == S_POST);
    assign trig_hit   = store && state_q == S_ARMED && trig_en && cap_pc == trig_pc;
    assign full       = count_q == CW'(DEPTH);
    assign pop        = state_q == S_DRAIN && rd_valid && rd_ready;
    assign rptr_nxt   = rptr_q + AW'(1);
    // The first entry is fetched one cycle after entering DRAIN so the final store has landed.
    assign load_first = state_q == S_DRAIN && !rd_valid && count_q != '0;
    assign rd_load    = !abort && (load_first || (pop && count_q != CW'(1)));
    assign rd_idx     = load_first ? rptr_q : rptr_nxt;

    assign state   = state_q;
    assign count   = count_q;
    assign wrapped = wrapped_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            post_q    <= '0;
            wrapped_q <= 1'b0;
            rd_valid  <= 1'b0;
        end else if (abort) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            rd_valid <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (arm) begin
                        state_q   <= S_ARMED;
                        wptr_q    <= '0;
                        rptr_q    <= '0;
                        count_q   <= '0;
                        wrapped_q <= 1'b0;
                    end
                end
                S_ARMED, S_POST: begin
                    if (store) begin
                        wptr_q <= wptr_q + AW'(1);
                        if (full) begin
                            rptr_q    <= rptr_q + AW'(1);
                            wrapped_q <= 1'b1;
                        end else begin
                            count_q <= count_q + CW'(1);
                        end
                    end
                    if (trig_hit) begin
                        post_q  <= CW'(POST_TRIG);
                        state_q <= (POST_TRIG == 0) ? S_DRAIN : S_POST;
                    end
                    if (state_q == S_POST && store) begin
                        post_q <= post_q - CW'(1);
                        if (post_q == CW'(1)) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (load_first) begin
                        rd_valid <= 1'b1;
                    end else if (pop) begin
                        rptr_q  <= rptr_nxt;
                        count_q <= count_q - CW'(1);
                        if (count_q == CW'(1)) begin
                            state_q  <= S_IDLE;
                            rd_valid <= 1'b0;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset && !abort && store) begin
            pc_mem[wptr_q]    <= cap_pc;
            instr_mem[wptr_q] <= cap_instr;
            we_mem[wptr_q]    <= cap_rd_we;
            addr_mem[wptr_q]  <= cap_rd_addr;
            data_mem[wptr_q]  <= cap_rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_pc    <= '0;
            rd_instr <= '0;
            rd_we    <= 1'b0;
            rd_addr  <= '0;
            rd_data  <= '0;
        end else if (rd_load) begin
            rd_pc    <= pc_mem[rd_idx];
            rd_instr <= instr_mem[rd_idx];
            rd_we    <= we_mem[rd_idx];
            rd_addr  <= addr_mem[rd_idx];
            rd_data  <= data_mem[rd_idx];
        end
    end

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts_q;
    logic [TS_WIDTH-1:0] ts_mem[DEPTH];

    always_ff @(posedge clk) begin
        if (!reset) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + TS_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset && !abort && store) begin
            ts_mem[wptr_q] <= ts_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ts <= '0;
        end else if (rd_load) begin
            rd_ts <= ts_mem[rd_idx];
        end
    end
`else
    assign rd_ts = '0;
`endif

endmodule

// File: tb/tb_retire_trace_buffer.sv
// tb/tb_retire_trace_buffer.sv - randomized bench for retire_trace_buffer against a queue-based trace model
module tb_retire_trace_buffer;

    localparam int XLEN      = 32;
    localparam int DEPTH     = 16;
    localparam int POST_TRIG = 8;
    localparam int TS_WIDTH  = 16;
`ifdef TRACE_TIMESTAMP_EN
    localparam bit TS_ON = 1'b1;
`else
    localparam bit TS_ON = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                reset;
    logic                cap_valid;
    logic [XLEN-1:0]     cap_pc;
    logic [31:0]         cap_instr;
    logic                cap_rd_we;
    logic [4:0]          cap_rd_addr;
    logic [XLEN-1:0]     cap_rd_data;
    logic                arm;
    logic                abort;
    logic                trig_en;
    logic [XLEN-1:0]     trig_pc;
    logic                rd_ready;
    logic                rd_valid;
    logic [XLEN-1:0]     rd_pc;
    logic [31:0]         rd_instr;
    logic                rd_we;
    logic [4:0]          rd_addr;
    logic [XLEN-1:0]     rd_data;
    logic [TS_WIDTH-1:0] rd_ts;
    logic [1:0]          state;
    logic [$clog2(DEPTH):0] count;
    logic                wrapped;

    retire_trace_buffer #(
        .XLEN(XLEN), .DEPTH(DEPTH), .POST_TRIG(POST_TRIG), .TS_WIDTH(TS_WIDTH)
    ) dut (
        .clk(clk), .reset(reset),
        .cap_valid(cap_valid), .cap_pc(cap_pc), .cap_instr(cap_instr),
        .cap_rd_we(cap_rd_we), .cap_rd_addr(cap_rd_addr), .cap_rd_data(cap_rd_data),
        .arm(arm), .abort(abort), .trig_en(trig_en), .trig_pc(trig_pc),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_instr(rd_instr),
        .rd_we(rd_we), .rd_addr(rd_addr), .rd_data(rd_data), .rd_ts(rd_ts),
        .state(state), .count(count), .wrapped(wrapped)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0]     pc;
        logic [31:0]         instr;
        logic                we;
        logic [4:0]          addr;
        logic [XLEN-1:0]     data;
        logic [TS_WIDTH-1:0] ts;
    } ent_t;

    int n_tests  = 0;
    int n_failed = 0;

    ent_t            q[$];
    int              m_state;
    bit              m_wrapped;
    int              m_post;
    int              m_ts;
    bit              stall_prev;
    logic [XLEN-1:0] hold_pc;
    logic [XLEN-1:0] hold_data;
    int              n_pops;
    int              drain_wait;
    logic [XLEN-1:0] popped_pc[$];
    logic [TS_WIDTH-1:0] popped_ts[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: what the trace holds is simply the newest DEPTH retires since arm.
    task automatic model_step();
        ent_t e;
        if (!reset) begin
            m_state    = 0;
            q.delete();
            m_wrapped  = 1'b0;
            m_ts       = 0;
            stall_prev = 1'b0;
        end else begin
            if (m_state == 3 && rd_valid) begin
                if (stall_prev) begin
                    chk("hold_pc", 64'(rd_pc), 64'(hold_pc));
                    chk("hold_data", 64'(rd_data), 64'(hold_data));
                end
                stall_prev = !rd_ready && !abort;
                hold_pc    = rd_pc;
                hold_data  = rd_data;
            end else begin
                stall_prev = 1'b0;
            end
            if (abort) begin
                m_state = 0;
                q.delete();
            end else begin
                case (m_state)
                    0: if (arm) begin
                        m_state   = 1;
                        q.delete();
                        m_wrapped = 1'b0;
                    end
                    1, 2: if (cap_valid) begin
                        e.pc    = cap_pc;
                        e.instr = cap_instr;
                        e.we    = cap_rd_we;
                        e.addr  = cap_rd_addr;
                        e.data  = cap_rd_data;
                        e.ts    = TS_WIDTH'(m_ts);
                        q.push_back(e);
                        if (q.size() > DEPTH) begin
                            void'(q.pop_front());
                            m_wrapped = 1'b1;
                        end
                        if (m_state == 1) begin
                            if (trig_en && cap_pc == trig_pc) begin
                                if (POST_TRIG == 0) m_state = 3;
                                else begin
                                    m_state = 2;
                                    m_post  = POST_TRIG;
                                end
                            end
                        end else begin
                            m_post--;
                            if (m_post == 0) m_state = 3;
                        end
                    end
                    3: if (rd_valid && rd_ready) begin
                        if (q.size() == 0) begin
                            chk("pop_nonempty", 64'(0), 64'(1));
                        end else begin
                            e = q.pop_front();
                            chk("pop_pc", 64'(rd_pc), 64'(e.pc));
                            chk("pop_instr", 64'(rd_instr), 64'(e.instr));
                            chk("pop_we", 64'(rd_we), 64'(e.we));
                            chk("pop_addr", 64'(rd_addr), 64'(e.addr));
                            chk("pop_data", 64'(rd_data), 64'(e.data));
                            chk("pop_ts", 64'(rd_ts), TS_ON ? 64'(e.ts) : 64'(0));
                        end
                        popped_pc.push_back(rd_pc);
                        popped_ts.push_back(rd_ts);
                        n_pops++;
                        if (q.size() == 0) m_state = 0;
                    end
                    default: m_state = 0;
                endcase
            end
            m_ts++;
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        chk("state", 64'(state), 64'(m_state));
        chk("count", 64'(count), 64'(q.size()));
        chk("wrapped", 64'(wrapped), 64'(m_wrapped));
        if (m_state == 3) begin
            if (!rd_valid) drain_wait++;
            else drain_wait = 0;
            chk("rd_latency", 64'(drain_wait > 1), 64'(0));
        end else begin
            drain_wait = 0;
            chk("rd_valid_idle", 64'(rd_valid), 64'(0));
        end
    endtask

    task automatic retire(input logic [XLEN-1:0] pc);
        cap_valid   = 1'b1;
        cap_pc      = pc;
        cap_instr   = $urandom;
        cap_rd_we   = 1'($urandom_range(0, 1));
        cap_rd_addr = 5'($urandom_range(0, 31));
        cap_rd_data = $urandom;
        cycle();
        cap_valid = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        cycle();
        arm = 1'b0;
        popped_pc.delete();
        popped_ts.delete();
    endtask

    task automatic drain_all();
        rd_ready = 1'b1;
        for (int i = 0; i < 4 * DEPTH && m_state == 3; i++) cycle();
        rd_ready = 1'b0;
        chk("drain_done", 64'(state), 64'(0));
    endtask

    initial begin
        int c0;
        int p0;
        reset = 1'b0; cap_valid = 1'b0; cap_pc = '0; cap_instr = '0; cap_rd_we = 1'b0;
        cap_rd_addr = '0; cap_rd_data = '0; arm = 1'b0; abort = 1'b0; trig_en = 1'b0;
        trig_pc = '0; rd_ready = 1'b0;
        n_pops = 0; drain_wait = 0; m_post = 0; m_state = 0; m_ts = 0; m_wrapped = 1'b0;
        stall_prev = 1'b0; hold_pc = '0; hold_data = '0;

        // Reset with noise on every input.
        cap_valid = 1'b1; cap_pc = $urandom; arm = 1'b1; abort = 1'b0; trig_en = 1'b1;
        trig_pc = cap_pc; rd_ready = 1'b1;
        repeat (2) cycle();
        reset = 1'b1; cap_valid = 1'b0; arm = 1'b0; rd_ready = 1'b0; trig_en = 1'b0;
        chk("rst_state", 64'(state), 64'(0));
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_rd_valid", 64'(rd_valid), 64'(0));
        chk("rst_wrapped", 64'(wrapped), 64'(0));
        chk("rst_rd_pc", 64'(rd_pc), 64'(0));

        // Basic trigger at 0x0C: 3 pre + trigger + 8 post.
        trig_en = 1'b1; trig_pc = 32'h0C;
        do_arm();
        for (int i = 0; i < 25; i++) retire(32'(i * 4));
        chk("basic_state", 64'(state), 64'(3));
        chk("basic_count", 64'(count), 64'(12));
        chk("basic_wrapped", 64'(wrapped), 64'(0));
        drain_all();
        chk("basic_n", 64'(popped_pc.size()), 64'(12));
        if (popped_pc.size() == 12) begin
            chk("basic_first", 64'(popped_pc[0]), 64'(32'h00));
            chk("basic_trig", 64'(popped_pc[3]), 64'(32'h0C));
            chk("basic_last", 64'(popped_pc[11]), 64'(32'h2C));
        end

        // Wrap: 40 untriggered retires, trigger at 0xA0, 8 post entries.
        trig_pc = 32'hA0;
        do_arm();
        for (int i = 0; i < 40; i++) retire(32'h1000 + 32'(i * 4));
        retire(32'hA0);
        for (int i = 0; i < POST_TRIG; i++) retire(32'h2000 + 32'(i * 4));
        chk("wrap_wrapped", 64'(wrapped), 64'(1));
        chk("wrap_count", 64'(count), 64'(16));

        // Backpressure inside that drain: ready 1,0,0,1 gives exactly two pops.
        for (int i = 0; i < 4 && !(m_state == 3 && rd_valid); i++) cycle();
        chk("bp_valid", 64'(rd_valid), 64'(1));
        c0 = q.size();
        p0 = n_pops;
        rd_ready = 1'b1; cycle();
        rd_ready = 1'b0; cycle();
        cycle();
        rd_ready = 1'b1; cycle();
        rd_ready = 1'b0;
        chk("bp_pops", 64'(n_pops - p0), 64'(2));
        chk("bp_count", 64'(count), 64'(c0 - 2));
        drain_all();
        chk("wrap_n", 64'(popped_pc.size()), 64'(16));
        if (popped_pc.size() == 16) begin
            chk("wrap_first", 64'(popped_pc[0]), 64'(32'h1084));
            chk("wrap_trig", 64'(popped_pc[7]), 64'(32'hA0));
            chk("wrap_last", 64'(popped_pc[15]), 64'(32'h201C));
        end

        // Abort mid-POST together with a matching retire.
        trig_pc = 32'h40;
        do_arm();
        retire(32'h100); retire(32'h104); retire(32'h40);
        for (int i = 0; i < 3; i++) retire(32'h200 + 32'(i * 4));
        chk("abort_pre_state", 64'(state), 64'(2));
        abort = 1'b1; cap_pc = 32'h40;
        retire(32'h40);
        abort = 1'b0;
        chk("abort_state", 64'(state), 64'(0));
        chk("abort_count", 64'(count), 64'(0));
        do_arm();
        chk("rearm_state", 64'(state), 64'(1));
        chk("rearm_count", 64'(count), 64'(0));
        abort = 1'b1; cycle(); abort = 1'b0;

        // Timestamps: retires at cycles 10, 11 and 15 after reset release.
        reset = 1'b0; repeat (2) cycle();
        reset = 1'b1; trig_pc = 32'h3C;
        arm = 1'b1; cycle(); arm = 1'b0;
        popped_ts.delete(); popped_pc.delete();
        repeat (9) cycle();
        retire(32'h34); retire(32'h38);
        repeat (3) cycle();
        retire(32'h3C);
        for (int i = 0; i < POST_TRIG; i++) retire(32'h400 + 32'(i * 4));
        drain_all();
        chk("ts_n", 64'(popped_ts.size()), 64'(11));
        if (popped_ts.size() == 11) begin
            chk("ts_0", 64'(popped_ts[0]), TS_ON ? 64'(10) : 64'(0));
            chk("ts_1", 64'(popped_ts[1]), TS_ON ? 64'(11) : 64'(0));
            chk("ts_2", 64'(popped_ts[2]), TS_ON ? 64'(15) : 64'(0));
        end

        // Random traffic: arms, triggers, aborts and backpressure all mixed.
        trig_pc = 32'h20;
        for (int i = 0; i < 3000; i++) begin
            cap_valid   = $urandom_range(0, 3) != 0;
            cap_pc      = 32'($urandom_range(0, 15) * 4);
            cap_instr   = $urandom;
            cap_rd_we   = 1'($urandom_range(0, 1));
            cap_rd_addr = 5'($urandom_range(0, 31));
            cap_rd_data = $urandom;
            trig_en     = $urandom_range(0, 7) != 0;
            arm         = $urandom_range(0, 11) == 0;
            abort       = $urandom_range(0, 149) == 0;
            rd_ready    = $urandom_range(0, 2) != 0;
            cycle();
        end
        cap_valid = 1'b0; arm = 1'b0; abort = 1'b0;
        if (m_state == 3) drain_all();
        abort = 1'b1; cycle(); abort = 1'b0;
        chk("end_idle", 64'(state), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
